// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - core/memory signal bundle for the data-memory access controller
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              core_cen;
    logic              core_wen;
    logic [ADDR_W-1:0] core_a;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    modport master (
        input  core_cen, core_wen, core_a, core_wdata, mem_ack, mem_rdata,
        output core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport slave (
        output core_cen, core_wen, core_a, core_wdata, mem_ack, mem_rdata,
        input  core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - stalls a single-cycle core across variable-latency data memory, with a one-word read buffer
module dmem_access_ctrl #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_access_ctrl_if.master   bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              err_q;

    logic req;
    logic hit;

    assign req = ~bus.core_cen;
    assign hit = (state == IDLE) && req && bus.core_wen && buf_valid && (buf_tag == bus.core_a);

    // Stall and hit data are combinational so a buffer hit costs no cycle.
    always_comb begin
        bus.core_stall = 1'b0;
        case (state)
            IDLE:    bus.core_stall = req && !hit;
            BUSY:    bus.core_stall = 1'b1;
            default: bus.core_stall = 1'b0;
        endcase
        bus.core_rdata = hit ? buf_data : rdata_q;
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            buf_valid   <= 1'b0;
            buf_tag     <= '0;
            buf_data    <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        rdata_q <= buf_data;
                    end else if (req) begin
                        mem_we_q    <= ~bus.core_wen;
                        mem_addr_q  <= bus.core_a;
                        mem_wdata_q <= bus.core_wdata;
                        mem_req_q   <= 1'b1;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the last allowed cycle still counts as success.
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= DONE;
                        if (!mem_we_q) begin
                            rdata_q   <= bus.mem_rdata;
                            buf_valid <= 1'b1;
                            buf_tag   <= mem_addr_q;
                            buf_data  <= bus.mem_rdata;
                        end else if (buf_valid && (buf_tag == mem_addr_q)) begin
                            buf_data <= mem_wdata_q;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        buf_valid <= 1'b0;
                        if (!mem_we_q) begin
                            rdata_q <= ERR_DATA;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed and randomized accesses against a behavioural memory/buffer model
module tb_dmem_access_ctrl;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] ERRD    = 32'hDEADBEEF;

    logic clk;
    logic rst_n;

    dmem_access_ctrl_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    dmem_access_ctrl #(.ADDR_W(7), .DATA_W(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] mem_m [128];
    bit          bvalid;
    logic [6:0]  btag;
    logic [31:0] bdata;
    logic [31:0] last_rd;
    bit          err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bvalid  = 1'b0;
        btag    = '0;
        bdata   = '0;
        last_rd = '0;
        err_m   = 1'b0;
    endtask

    // Entered just after a rising edge; leaves just after a rising edge with the core idle.
    task automatic run_access(input string tag, input bit we, input logic [6:0] a,
                              input logic [31:0] wd, input int d);
        bit          is_hit;
        bit          done;
        int          exp_stalls;
        int          exp_busy;
        int          stalls;
        int          busy;
        logic [31:0] exp_rd;
        logic [31:0] rd;
        logic        err_o;

        is_hit     = !we && bvalid && (btag == a);
        exp_stalls = is_hit ? 0 : ((d <= TIMEOUT) ? d + 1 : TIMEOUT + 1);
        exp_busy   = is_hit ? 0 : ((d <= TIMEOUT) ? d : TIMEOUT);

        bus.core_cen   = 1'b0;
        bus.core_wen   = ~we;
        bus.core_a     = a;
        bus.core_wdata = wd;
        stalls = 0;
        busy   = 0;
        done   = 1'b0;
        rd     = '0;
        err_o  = 1'b0;
        for (int k = 0; k < 3 * TIMEOUT; k++) begin
            @(negedge clk);
            if (!bus.core_stall) begin
                rd    = bus.core_rdata;
                err_o = bus.err;
                done  = 1'b1;
                break;
            end
            stalls++;
            if (bus.mem_req) begin
                busy++;
                check({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
                check({tag, "_we"}, 32'(bus.mem_we), 32'(we));
                if (we) check({tag, "_wdata"}, bus.mem_wdata, wd);
                bus.mem_ack   = (busy == d);
                bus.mem_rdata = (busy == d) ? mem_m[a] : $urandom;
            end
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
        end
        check({tag, "_completed"}, 32'(done), 32'd1);

        if (is_hit) begin
            exp_rd = bdata;
        end else if (d <= TIMEOUT) begin
            if (we) begin
                exp_rd  = last_rd;
                mem_m[a] = wd;
                if (bvalid && btag == a) bdata = wd;
            end else begin
                exp_rd = mem_m[a];
                bvalid = 1'b1;
                btag   = a;
                bdata  = mem_m[a];
            end
        end else begin
            exp_rd = we ? last_rd : ERRD;
            err_m  = 1'b1;
            bvalid = 1'b0;
        end
        last_rd = exp_rd;

        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(err_o), 32'(err_m));

        @(posedge clk);
        #1;
        bus.core_cen = 1'b1;
        @(negedge clk);
        check({tag, "_idle_stall"}, 32'(bus.core_stall), 32'd0);
        check({tag, "_idle_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_idle_rdata"}, bus.core_rdata, last_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.core_cen   = 1'b1;
        bus.core_wen   = 1'b1;
        bus.core_a     = '0;
        bus.core_wdata = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        for (int i = 0; i < 128; i++) mem_m[i] = $urandom;
        model_reset();

        // Reset held while the memory side toggles ack.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.mem_ack = ~bus.mem_ack;
            @(negedge clk);
            check("rst_req", 32'(bus.mem_req), 32'd0);
            check("rst_outs", {bus.core_rdata[31:4], bus.core_rdata[3:0] | {bus.mem_we, bus.err, bus.core_stall, 1'b0}},
                  32'd0);
            check("rst_addr_wdata", bus.mem_wdata | 32'(bus.mem_addr), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);
        check("post_rst_stall", 32'(bus.core_stall), 32'd0);
        @(posedge clk);
        #1;

        mem_m[5] = 32'h1234_5678;
        run_access("t2_read5", 1'b0, 7'd5, 32'h0, 3);
        run_access("t2_hit5", 1'b0, 7'd5, 32'h0, 3);
        run_access("t3_write5", 1'b1, 7'd5, 32'hCAFE_0001, 1);
        run_access("t3_hit5", 1'b0, 7'd5, 32'h0, 2);
        run_access("t3_write6", 1'b1, 7'd6, 32'h0BAD_0006, 2);
        run_access("t3_hit5b", 1'b0, 7'd5, 32'h0, 2);
        run_access("t4_timeout9", 1'b0, 7'd9, 32'h0, 100);
        run_access("t4_miss5", 1'b0, 7'd5, 32'h0, 1);

        // Late ack on the final count cycle is a success on a fresh reset.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        run_access("t5_ack_last", 1'b0, 7'd11, 32'h0, TIMEOUT);

        // Reset mid-transaction, then a stray ack.
        bus.core_cen = 1'b0;
        bus.core_wen = 1'b1;
        bus.core_a   = 7'd7;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t6_req_mid", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_req_rst", 32'(bus.mem_req), 32'd0);
        bus.core_cen = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        bus.mem_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("t6_stray_req", 32'(bus.mem_req), 32'd0);
        check("t6_stray_stall", 32'(bus.core_stall), 32'd0);
        @(posedge clk);
        #1;
        run_access("t6_miss5", 1'b0, 7'd5, 32'h0, 2);

        for (int n = 0; n < 60; n++) begin
            int r;
            int d;
            r = int'($urandom_range(0, 9));
            d = (r == 0) ? TIMEOUT + 2 : ((r == 1) ? TIMEOUT : int'($urandom_range(1, 5)));
            run_access("rnd", 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), $urandom, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
